// File: rtl/RS5_pkg.sv
// Shared RS5 core types: instruction classes, atomic sub-operations and AMO controller states.
package RS5_pkg;

   typedef enum logic [3:0] {
      NOP, LUI, ADD, LOAD, STORE, BRANCH, LR_W, SC_W, AMO_W
   } iType_e;

   typedef enum logic [3:0] {
      AMONOP, AMOSWAP, AMOADD, AMOXOR, AMOAND, AMOOR,
      AMOMIN, AMOMAX, AMOMINU, AMOMAXU
   } iTypeAtomic_e;

   typedef enum logic [1:0] {
      A_IDLE, A_READ, A_WRITE, A_DONE
   } amo_states_e;

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write function for AMO_W: new value from old memory word and rs2.
module amo_alu
   import RS5_pkg::*;
(
   input  iTypeAtomic_e op,
   input  logic [31:0]  old,
   input  logic [31:0]  rs2,
   output logic [31:0]  new_val
);

   logic signed_lt;
   logic unsigned_lt;

   always_comb begin
      signed_lt   = $signed(old) < $signed(rs2);
      unsigned_lt = old < rs2;
      new_val     = old;
      case (op)
         AMOSWAP: new_val = rs2;
         AMOADD:  new_val = old + rs2;
         AMOXOR:  new_val = old ^ rs2;
         AMOAND:  new_val = old & rs2;
         AMOOR:   new_val = old | rs2;
         AMOMIN:  new_val = signed_lt   ? old : rs2;
         AMOMAX:  new_val = signed_lt   ? rs2 : old;
         AMOMINU: new_val = unsigned_lt ? old : rs2;
         AMOMAXU: new_val = unsigned_lt ? rs2 : old;
         default: new_val = old;
      endcase
   end

endmodule

// File: rtl/amo_controller.sv
// Atomic memory operation sequencer (LR_W / SC_W / AMO_W) with a single reservation register.
// LR/SC support and the reservation exist only when RS5_AMO_LRSC_EN is defined.
//
//   state   | meaning
//   A_IDLE  | waiting for start_i; only state where a request is accepted
//   A_READ  | memory read outstanding (LR_W, AMO_W)
//   A_WRITE | memory write outstanding (AMO_W new value, SC_W store)
//   A_DONE  | one-cycle completion, result/flags valid
module amo_controller
   import RS5_pkg::*;
#(
   parameter int RESV_GRANULE_LSB = 2
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start_i,
   input  iType_e       instruction_operation_i,
   input  iTypeAtomic_e atomic_operation_i,
   input  logic [31:0]  address_i,
   input  logic [31:0]  rs2_data_i,
   output logic         mem_req_o,
   output logic         mem_we_o,
   output logic [31:0]  mem_addr_o,
   output logic [31:0]  mem_wdata_o,
   input  logic         mem_ready_i,
   input  logic [31:0]  mem_rdata_i,
   input  logic         snoop_we_i,
   input  logic [31:0]  snoop_addr_i,
   input  logic         flush_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         illegal_o,
   output logic         misaligned_o,
   output logic [31:0]  result_o
);

   amo_states_e  state, next_state;
   iType_e       op_q;
   iTypeAtomic_e aop_q;
   logic [31:0]  addr_q, rs2_q, data_q, alu_new;
   logic         illegal_q, misaligned_q;
   logic         accept, abort, read_done;
   logic         req_legal, req_misaligned, sc_success;
   logic         unused_snoop;

   assign accept         = (state == A_IDLE) && start_i && !flush_i;
   assign abort          = flush_i && ((state == A_IDLE) || (state == A_READ));
   assign read_done      = (state == A_READ) && mem_ready_i && !flush_i;
   assign req_misaligned = address_i[1:0] != 2'b00;
   assign unused_snoop   = ^{snoop_we_i, snoop_addr_i};

`ifdef RS5_AMO_LRSC_EN
   logic                         resv_valid;
   logic [31:RESV_GRANULE_LSB]   resv_addr;
   logic                         snoop_hit;

   assign snoop_hit  = snoop_we_i && resv_valid &&
                       (snoop_addr_i[31:RESV_GRANULE_LSB] == resv_addr);
   // A snoop landing in the same cycle as SC accept must make the SC fail.
   assign sc_success = resv_valid && !snoop_hit &&
                       (address_i[31:RESV_GRANULE_LSB] == resv_addr);
   assign req_legal  = ((instruction_operation_i == AMO_W) && (atomic_operation_i != AMONOP)) ||
                       (instruction_operation_i == LR_W) || (instruction_operation_i == SC_W);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         resv_valid <= 1'b0;
         resv_addr  <= '0;
      end else if (abort) begin
         resv_valid <= 1'b0;
      end else if (read_done && (op_q == LR_W)) begin
         resv_valid <= 1'b1;
         resv_addr  <= addr_q[31:RESV_GRANULE_LSB];
      end else if (snoop_hit || (accept && (instruction_operation_i == SC_W))) begin
         resv_valid <= 1'b0;
      end
   end
`else
   logic unused_lrsc;

   assign unused_lrsc = snoop_addr_i[RESV_GRANULE_LSB];
   assign sc_success  = 1'b0;
   assign req_legal   = (instruction_operation_i == AMO_W) && (atomic_operation_i != AMONOP);
`endif

   amo_alu u_alu (
      .op      (aop_q),
      .old     (data_q),
      .rs2     (rs2_q),
      .new_val (alu_new)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state <= A_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state   = state;
      busy_o       = state != A_IDLE;
      mem_req_o    = (state == A_READ) || (state == A_WRITE);
      mem_we_o     = state == A_WRITE;
      mem_addr_o   = 32'd0;
      mem_wdata_o  = 32'd0;
      done_o       = state == A_DONE;
      result_o     = 32'd0;
      illegal_o    = 1'b0;
      misaligned_o = 1'b0;

      case (state)
         A_IDLE: begin
            if (accept) begin
               if (!req_legal || req_misaligned)
                  next_state = A_DONE;
               else if (instruction_operation_i == SC_W)
                  next_state = sc_success ? A_WRITE : A_DONE;
               else
                  next_state = A_READ;
            end
         end
         A_READ: begin
            mem_addr_o = addr_q;
            if (flush_i)
               next_state = A_IDLE;
            else if (mem_ready_i)
               next_state = (op_q == LR_W) ? A_DONE : A_WRITE;
         end
         A_WRITE: begin
            mem_addr_o  = addr_q;
            mem_wdata_o = (op_q == SC_W) ? rs2_q : alu_new;
            if (mem_ready_i)
               next_state = A_DONE;
         end
         A_DONE: begin
            result_o     = data_q;
            illegal_o    = illegal_q;
            misaligned_o = misaligned_q;
            next_state   = A_IDLE;
         end
         default: next_state = A_IDLE;
      endcase
   end

   // data_q holds the SC status after accept, then the old memory word once the read returns.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_q         <= NOP;
         aop_q        <= AMONOP;
         addr_q       <= 32'd0;
         rs2_q        <= 32'd0;
         data_q       <= 32'd0;
         illegal_q    <= 1'b0;
         misaligned_q <= 1'b0;
      end else if (accept) begin
         op_q         <= instruction_operation_i;
         aop_q        <= atomic_operation_i;
         addr_q       <= address_i;
         rs2_q        <= rs2_data_i;
         illegal_q    <= !req_legal;
         misaligned_q <= req_legal && req_misaligned;
         data_q       <= (req_legal && !req_misaligned && (instruction_operation_i == SC_W) &&
                          !sc_success) ? 32'd1 : 32'd0;
      end else if (read_done) begin
         data_q <= mem_rdata_i;
      end
   end

endmodule
